// File: rtl/sargantana_icache_pkg.sv
// ----------------------------------------------------------------------------
// sargantana_icache_pkg
// Shared types and constants for the instruction-cache refill engine.
//   - refill_state_e : refill FSM states
//   - N_BEATS        : memory beats per cache line (default geometry)
//   - BEAT_CNT_W     : width of the beat counter (default geometry)
//   - line_addr_t    : {tag, idx} line address (default geometry)
// ----------------------------------------------------------------------------
package sargantana_icache_pkg;

    localparam int unsigned ICACHE_DEF_N_WAY     = 4;
    localparam int unsigned ICACHE_DEF_TAG_WIDHT = 20;
    localparam int unsigned ICACHE_DEF_IDX_WIDTH = 6;
    localparam int unsigned ICACHE_DEF_LINE_W    = 512;
    localparam int unsigned ICACHE_DEF_BEAT_W    = 128;

    localparam int unsigned N_BEATS    = ICACHE_DEF_LINE_W / ICACHE_DEF_BEAT_W;
    localparam int unsigned BEAT_CNT_W = $clog2(N_BEATS);

    typedef enum logic [1:0] {
        REFILL_IDLE  = 2'd0,
        REFILL_REQ   = 2'd1,
        REFILL_FILL  = 2'd2,
        REFILL_WRITE = 2'd3
    } refill_state_e;

    typedef logic [ICACHE_DEF_TAG_WIDHT+ICACHE_DEF_IDX_WIDTH-1:0] line_addr_t;

endpackage

// File: rtl/sargantana_icache_refill_victim_sel.sv
// ----------------------------------------------------------------------------
// sargantana_icache_victim_sel
// Picks the way to overwrite on a refill. The lowest-index invalid way wins;
// when the set is full the way comes from a replacement source:
//   ICACHE_REFILL_LFSR_EN undefined : round-robin pointer, advanced by update_i
//   ICACHE_REFILL_LFSR_EN defined   : 8-bit Fibonacci LFSR stepping every cycle
// Ports:
//   clk_i, rstn_i   clock, async active-low reset
//   valid_bits_i    valid bits of the indexed set
//   update_i        a completed write used the pointer; advance it
//   way_o           one-hot victim way (combinational)
// ----------------------------------------------------------------------------
module sargantana_icache_victim_sel
    import sargantana_icache_pkg::*;
#(
    parameter int unsigned ICACHE_N_WAY = 4
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic [ICACHE_N_WAY-1:0] valid_bits_i,
    input  logic                    update_i,
    output logic [ICACHE_N_WAY-1:0] way_o
);

    localparam int unsigned PTR_W = $clog2(ICACHE_N_WAY);

    logic [PTR_W-1:0] inv_idx_s;
    logic             inv_found_s;
    logic [PTR_W-1:0] repl_idx_s;
    logic [PTR_W-1:0] sel_idx_s;

`ifdef ICACHE_REFILL_LFSR_EN
    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // LFSR next value: taps 8,6,5,4 shifted in at the bottom
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    // LFSR register, free-running
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            lfsr_q <= 8'h01;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign repl_idx_s = lfsr_q[PTR_W-1:0];
`else
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Round-robin pointer next value; wraps naturally since N_WAY is a power of two
    always_comb begin
        if (update_i) begin
            ptr_d = ptr_q + PTR_W'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign repl_idx_s = ptr_q;
`endif

    // Lowest-index invalid way search
    always_comb begin
        inv_found_s = 1'b0;
        inv_idx_s   = '0;
        for (int i = 0; i < int'(ICACHE_N_WAY); i++) begin
            if (!inv_found_s && !valid_bits_i[i]) begin
                inv_found_s = 1'b1;
                inv_idx_s   = PTR_W'(i);
            end else begin
                inv_found_s = inv_found_s;
            end
        end
    end

    // Final selection and one-hot encode
    always_comb begin
        if (inv_found_s) begin
            sel_idx_s = inv_idx_s;
        end else begin
            sel_idx_s = repl_idx_s;
        end
        way_o            = '0;
        way_o[sel_idx_s] = 1'b1;
    end

endmodule

// File: rtl/sargantana_icache_refill.sv
// ----------------------------------------------------------------------------
// sargantana_icache_refill
// Instruction-cache refill engine: accepts a lookup miss, requests the line
// from memory, assembles the response beats and writes tag+data+valid into
// the icache arrays in one cycle. Owns the only array write port.
// Optional feature macro: ICACHE_REFILL_LFSR_EN (LFSR victim for full sets).
// Ports:
//   clk_i, rstn_i            clock, async active-low reset
//   miss_*                   miss request from lookup (valid/ready, tag, idx,
//                            way_valid_bits_i sampled on acceptance)
//   flush_i                  cancels the current refill
//   mem_req_*                line request to memory ({tag, idx} address)
//   mem_rsp_*                response beats, lowest address first, error flag
//   wr_*                     array write strobe, one-hot way, idx, tag, line
//   done_o / err_o           end-of-refill pulse, qualified by error
// ----------------------------------------------------------------------------
module sargantana_icache_refill
    import sargantana_icache_pkg::*;
#(
    parameter int unsigned ICACHE_N_WAY = 4,
    parameter int unsigned TAG_WIDHT    = 20,
    parameter int unsigned IDX_WIDTH    = 6,
    parameter int unsigned LINE_WIDTH   = 512,
    parameter int unsigned BEAT_WIDTH   = 128
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic                           miss_valid_i,
    output logic                           miss_ready_o,
    input  logic [TAG_WIDHT-1:0]           miss_tag_i,
    input  logic [IDX_WIDTH-1:0]           miss_idx_i,
    input  logic [ICACHE_N_WAY-1:0]        way_valid_bits_i,
    input  logic                           flush_i,
    output logic                           mem_req_valid_o,
    input  logic                           mem_req_ready_i,
    output logic [TAG_WIDHT+IDX_WIDTH-1:0] mem_req_addr_o,
    input  logic                           mem_rsp_valid_i,
    output logic                           mem_rsp_ready_o,
    input  logic [BEAT_WIDTH-1:0]          mem_rsp_data_i,
    input  logic                           mem_rsp_error_i,
    output logic                           wr_en_o,
    output logic [ICACHE_N_WAY-1:0]        wr_way_o,
    output logic [IDX_WIDTH-1:0]           wr_idx_o,
    output logic [TAG_WIDHT-1:0]           wr_tag_o,
    output logic [LINE_WIDTH-1:0]          wr_data_o,
    output logic                           done_o,
    output logic                           err_o
);

    localparam int unsigned LINE_BEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int unsigned CNT_W      = $clog2(LINE_BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);

    refill_state_e           state_q, state_d;
    logic                    ready_q, ready_d;
    logic [TAG_WIDHT-1:0]    tag_q, tag_d;
    logic [IDX_WIDTH-1:0]    idx_q, idx_d;
    logic [ICACHE_N_WAY-1:0] way_q, way_d;
    logic                    used_ptr_q, used_ptr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    err_flag_q, err_flag_d;
    logic                    abort_q, abort_d;
    logic                    flush_done_q, flush_done_d;
    logic [LINE_WIDTH-1:0]   line_q, line_d;

    logic [ICACHE_N_WAY-1:0] victim_way_s;
    logic                    write_s;

    // A write happens only in WRITE with neither error nor abort recorded
    assign write_s = (state_q == REFILL_WRITE) && !err_flag_q && !abort_q;

    sargantana_icache_victim_sel #(
        .ICACHE_N_WAY (ICACHE_N_WAY)
    ) u_victim_sel (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .valid_bits_i (way_valid_bits_i),
        .update_i     (write_s && used_ptr_q),
        .way_o        (victim_way_s)
    );

    // Refill FSM next-state and datapath next values
    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        idx_d        = idx_q;
        way_d        = way_q;
        used_ptr_d   = used_ptr_q;
        cnt_d        = cnt_q;
        err_flag_d   = err_flag_q;
        abort_d      = abort_q;
        flush_done_d = 1'b0;
        line_d       = line_q;

        case (state_q)
            REFILL_IDLE: begin
                // ready_q is low for one cycle after reset; flush blocks acceptance
                if (ready_q && miss_valid_i && !flush_i) begin
                    tag_d      = miss_tag_i;
                    idx_d      = miss_idx_i;
                    way_d      = victim_way_s;
                    used_ptr_d = &way_valid_bits_i;
                    cnt_d      = '0;
                    err_flag_d = 1'b0;
                    abort_d    = 1'b0;
                    state_d    = REFILL_REQ;
                end else begin
                    state_d = REFILL_IDLE;
                end
            end
            REFILL_REQ: begin
                if (mem_req_ready_i) begin
                    // Request is out: a flush now must still drain the beats
                    abort_d = abort_q | flush_i;
                    state_d = REFILL_FILL;
                end else if (flush_i) begin
                    flush_done_d = 1'b1;
                    state_d      = REFILL_IDLE;
                end else begin
                    state_d = REFILL_REQ;
                end
            end
            REFILL_FILL: begin
                abort_d = abort_q | flush_i;
                if (mem_rsp_valid_i) begin
                    line_d[cnt_q*BEAT_WIDTH +: BEAT_WIDTH] = mem_rsp_data_i;
                    err_flag_d = err_flag_q | mem_rsp_error_i;
                    cnt_d      = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = REFILL_WRITE;
                    end else begin
                        state_d = REFILL_FILL;
                    end
                end else begin
                    state_d = REFILL_FILL;
                end
            end
            REFILL_WRITE: begin
                state_d = REFILL_IDLE;
            end
            default: begin
                state_d = REFILL_IDLE;
            end
        endcase

        // Ready is registered so that it reads 0 while in reset
        ready_d = (state_d == REFILL_IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= REFILL_IDLE;
            ready_q      <= 1'b0;
            tag_q        <= '0;
            idx_q        <= '0;
            way_q        <= '0;
            used_ptr_q   <= 1'b0;
            cnt_q        <= '0;
            err_flag_q   <= 1'b0;
            abort_q      <= 1'b0;
            flush_done_q <= 1'b0;
            line_q       <= '0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            tag_q        <= tag_d;
            idx_q        <= idx_d;
            way_q        <= way_d;
            used_ptr_q   <= used_ptr_d;
            cnt_q        <= cnt_d;
            err_flag_q   <= err_flag_d;
            abort_q      <= abort_d;
            flush_done_q <= flush_done_d;
            line_q       <= line_d;
        end
    end

    assign miss_ready_o    = ready_q;
    assign mem_req_valid_o = (state_q == REFILL_REQ);
    assign mem_req_addr_o  = {tag_q, idx_q};
    assign mem_rsp_ready_o = (state_q == REFILL_FILL);
    assign wr_en_o         = write_s;
    assign wr_way_o        = way_q;
    assign wr_idx_o        = idx_q;
    assign wr_tag_o        = tag_q;
    assign wr_data_o       = line_q;
    // Early flush from REQ reports completion in the following IDLE cycle
    assign done_o          = (state_q == REFILL_WRITE) || flush_done_q;
    assign err_o           = (state_q == REFILL_WRITE) && err_flag_q;

endmodule
